// File: rtl/pixel_serializer.sv
// Double-buffered parallel-to-serial shifter; each bit is stretched over DIV clocks, LSB or MSB first.
// Optional sticky underrun flag is built when PIXEL_SERIALIZER_UNDERRUN_EN is defined.
module pixel_serializer #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] inData,
  input  logic             inValid,
  output logic             inReady,
  input  logic             flush,
  input  logic             clrUnderrun,
  output logic             out,
  output logic             active,
  output logic             underrun
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             hold_full_q, hold_full_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;

  logic bit_end;
  logic word_end;
  logic accept;
  logic load;

  assign bit_end  = (timer_q == TW'(DIV - 1));
  assign word_end = (state_q == SHIFT) && bit_end && (cnt_q == CW'(WIDTH - 1));
  assign accept   = inValid && !hold_full_q;
  // A transfer needs a full hold register and an accept needs an empty one, so they never collide.
  assign load     = !flush && hold_full_q && ((state_q == IDLE) || word_end);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      timer_q     <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (load) begin
      state_d = SHIFT;
    end else if (word_end) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    timer_d     = timer_q;
    cnt_d       = cnt_q;
    if (flush) begin
      hold_full_d = 1'b0;
      shift_d     = '0;
      timer_d     = '0;
      cnt_d       = '0;
    end else begin
      if (accept) begin
        hold_d      = inData;
        hold_full_d = 1'b1;
      end
      if (load) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
        timer_d     = '0;
        cnt_d       = '0;
      end else if (state_q == SHIFT) begin
        if (bit_end) begin
          timer_d = '0;
          cnt_d   = word_end ? '0 : cnt_q + CW'(1);
          shift_d = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    end
    // The output flop always shows the head of the next shift value, so the first bit leaves with the load.
    out_d = (state_d == SHIFT) &&
            ((MSB_FIRST != 0) ? shift_d[WIDTH-1] : shift_d[0]);
  end

  assign inReady = !hold_full_q;
  assign active  = (state_q == SHIFT);
  assign out     = out_q;

`ifdef PIXEL_SERIALIZER_UNDERRUN_EN
  logic underrun_q, underrun_d;

  // Producer was still sending but missed the reload window of the finishing word.
  always_comb begin
    underrun_d = underrun_q;
    if (clrUnderrun) begin
      underrun_d = 1'b0;
    end else if (word_end && !hold_full_q && inValid) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun = underrun_q;
`else
  logic unused_clr_underrun;
  assign unused_clr_underrun = clrUnderrun;
  assign underrun            = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_serializer.sv
// Bench for pixel_serializer: two instances (DIV=1 LSB-first, DIV=2 MSB-first) share stimulus,
// each checked against a clocks-since-load reference model plus directed expectations.
module tb_pixel_serializer;

`ifdef PIXEL_SERIALIZER_UNDERRUN_EN
  localparam bit UND_EN = 1'b1;
`else
  localparam bit UND_EN = 1'b0;
`endif

  logic       clk;
  logic       n_reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       flush;
  logic       clr;
  logic       rdy0, out0, act0, und0;
  logic       rdy1, out1, act1, und1;

  int checks   = 0;
  int failures = 0;

  pixel_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) dut0 (
    .clk(clk), .nReset(n_reset), .inData(in_data), .inValid(in_valid), .inReady(rdy0),
    .flush(flush), .clrUnderrun(clr), .out(out0), .active(act0), .underrun(und0));

  pixel_serializer #(.WIDTH(8), .DIV(2), .MSB_FIRST(1)) dut1 (
    .clk(clk), .nReset(n_reset), .inData(in_data), .inValid(in_valid), .inReady(rdy1),
    .flush(flush), .clrUnderrun(clr), .out(out1), .active(act1), .underrun(und1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a word being sent is described by the number of clocks elapsed since it was loaded.
  typedef struct {
    bit         hold_full;
    logic [7:0] hold;
    bit         busy;
    logic [7:0] word;
    int         elapsed;
    bit         und;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.hold_full = 1'b0; r.hold = '0; r.busy = 1'b0; r.word = '0; r.elapsed = 0; r.und = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int div, bit v, logic [7:0] d, bit fl, bit cl);
    mdl_t n;
    bit eow, acc;
    n   = m;
    eow = m.busy && (m.elapsed == 8 * div - 1);
    acc = v && !m.hold_full;
    if (UND_EN) begin
      if (cl) n.und = 1'b0;
      else if (eow && !m.hold_full && v) n.und = 1'b1;
    end
    if (fl) begin
      n.hold_full = 1'b0; n.busy = 1'b0; n.elapsed = 0;
      return n;
    end
    if (m.busy && !eow) begin
      n.elapsed = m.elapsed + 1;
    end else if (m.hold_full) begin
      n.busy = 1'b1; n.word = m.hold; n.elapsed = 0; n.hold_full = 1'b0;
    end else begin
      n.busy = 1'b0;
    end
    if (acc) begin
      n.hold = d; n.hold_full = 1'b1;
    end
    return n;
  endfunction

  function automatic bit mdl_out(mdl_t m, int div, bit msb);
    int idx;
    if (!m.busy) return 1'b0;
    idx = m.elapsed / div;
    return msb ? m.word[7 - idx] : m.word[idx];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m0 = mdl_step(m0, 1, in_valid, in_data, flush, clr);
    m1 = mdl_step(m1, 2, in_valid, in_data, flush, clr);
    #1;
    check("m0_out", {31'd0, out0}, {31'd0, mdl_out(m0, 1, 1'b0)});
    check("m0_active", {31'd0, act0}, {31'd0, m0.busy});
    check("m0_ready", {31'd0, rdy0}, {31'd0, !m0.hold_full});
    check("m0_underrun", {31'd0, und0}, {31'd0, m0.und});
    check("m1_out", {31'd0, out1}, {31'd0, mdl_out(m1, 2, 1'b1)});
    check("m1_active", {31'd0, act1}, {31'd0, m1.busy});
    check("m1_ready", {31'd0, rdy1}, {31'd0, !m1.hold_full});
    check("m1_underrun", {31'd0, und1}, {31'd0, m1.und});
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] seq0;
    logic [7:0] seq1;
  } vec_t;

  vec_t vecs[6];
  int   rdy_highs;

  initial begin
    // Time-ordered bit sequences, first bit leftmost.
    vecs[0] = '{8'hA5, 8'b10100101, 8'b10100101};
    vecs[1] = '{8'hC3, 8'b11000011, 8'b11000011};
    vecs[2] = '{8'h01, 8'b10000000, 8'b00000001};
    vecs[3] = '{8'h80, 8'b00000001, 8'b10000000};
    vecs[4] = '{8'h3C, 8'b00111100, 8'b00111100};
    vecs[5] = '{8'h0E, 8'b01110000, 8'b00001110};

    n_reset = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0; clr = 1'b0;
    m0 = mdl_reset(); m1 = mdl_reset();
    #2;
    check("rst_out", {31'd0, out0}, 32'd0);
    check("rst_active", {31'd0, act0}, 32'd0);
    check("rst_ready", {31'd0, rdy0}, 32'd1);
    check("rst_underrun", {31'd0, und0}, 32'd0);
    check("rst_ready1", {31'd0, rdy1}, 32'd1);
    #10;
    n_reset = 1'b1;
    idle_ticks(2);

    // Single words into an idle block: edge 0 accepts, bits follow on edges 1..8 (DIV=1) / 1..16 (DIV=2).
    for (int v = 0; v < 6; v++) begin
      in_valid = 1'b1; in_data = vecs[v].data;
      tick();
      in_valid = 1'b0; in_data = '0;
      for (int e = 1; e <= 17; e++) begin
        tick();
        if (e <= 8) check("vec_out0", {31'd0, out0}, {31'd0, vecs[v].seq0[8 - e]});
        if (e == 9) check("vec_done0", {31'd0, act0}, 32'd0);
        if (e <= 16) begin
          check("vec_out1", {31'd0, out1}, {31'd0, vecs[v].seq1[7 - (e - 1) / 2]});
          check("vec_act1", {31'd0, act1}, 32'd1);
        end
        if (e == 17) check("vec_done1", {31'd0, act1}, 32'd0);
      end
    end

    // Back-to-back FF then 00: no gap, active stays high, inReady high once during the first word.
    rdy_highs = 0;
    for (int e = 0; e <= 17; e++) begin
      in_valid = (e <= 2);
      in_data  = (e == 0) ? 8'hFF : 8'h00;
      tick();
      if (e >= 1 && e <= 16) begin
        check("b2b_out", {31'd0, out0}, {31'd0, (e <= 8)});
        check("b2b_active", {31'd0, act0}, 32'd1);
      end
      if (e >= 1 && e <= 8 && rdy0) rdy_highs++;
      if (e == 17) check("b2b_done", {31'd0, act0}, 32'd0);
    end
    in_valid = 1'b0;
    check("b2b_ready_pulses", rdy_highs, 32'd1);
    idle_ticks(20);

    // Underrun: producer re-appears exactly on the end-of-word edge with nothing buffered.
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    idle_ticks(8);
    check("und_before", {31'd0, und0}, 32'd0);
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_valid = 1'b0;
    check("und_set", {31'd0, und0}, {31'd0, UND_EN});
    idle_ticks(5);
    check("und_sticky", {31'd0, und0}, {31'd0, UND_EN});
    idle_ticks(3);
    in_valid = 1'b1; in_data = 8'h22; clr = 1'b1;
    tick();
    in_valid = 1'b0; clr = 1'b0;
    check("und_clr_priority", {31'd0, und0}, 32'd0);
    idle_ticks(25);
    check("und_stays_clear", {31'd0, und0}, 32'd0);

    // Flush at bit 3 of F0 while a second word waits in hold.
    in_valid = 1'b1; in_data = 8'hF0;
    tick();
    in_data = 8'hAA;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("fl_hold_full", {31'd0, rdy0}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_out", {31'd0, out0}, 32'd0);
    check("fl_active", {31'd0, act0}, 32'd0);
    check("fl_ready", {31'd0, rdy0}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("fl_quiet", {30'd0, act0, out0}, 32'd0);
    end

    // Asynchronous reset between edges in the middle of a word.
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    idle_ticks(3);
    #3;
    n_reset = 1'b0;
    #1;
    check("ar_out", {31'd0, out0}, 32'd0);
    check("ar_active", {31'd0, act0}, 32'd0);
    check("ar_ready", {31'd0, rdy0}, 32'd1);
    check("ar_active1", {31'd0, act1}, 32'd0);
    m0 = mdl_reset(); m1 = mdl_reset();
    #2;
    n_reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("ar_quiet", {30'd0, act0, out0}, 32'd0);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      flush    = ($urandom_range(0, 149) == 0);
      clr      = ($urandom_range(0, 29) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; clr = 1'b0;
    idle_ticks(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
